// File: rtl/inf_key_ctrl.sv
// inf_key_ctrl: turns decoded NEC frames and repeat pulses into a
// PRESS / HOLD / RELEASE event stream delivered over valid/ready.
//
// Ports
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   frm_vld            : one-cycle pulse, a full frame was decoded
//   frm_ok             : inverse-byte checks passed (qualifies frm_vld)
//   frm_addr, frm_cmd  : frame address / command (qualify frm_vld)
//   rpt_vld            : one-cycle pulse, repeat code received
//   evt_valid/ready    : first-word fall-through event FIFO handshake
//   evt_type, evt_cmd  : head event (00 PRESS, 01 HOLD, 10 RELEASE)
//   key_active         : a key is currently pressed or held
//   err_cnt            : rejected frames, saturating
//   ovf                : sticky, a PRESS or RELEASE could not be queued
module inf_key_ctrl #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned RELEASE_MS = 120,
  parameter logic [7:0]  ADDR_MATCH = 8'h57,
  parameter bit          ADDR_EN    = 1'b1,
  parameter int unsigned HOLD_DELAY = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       frm_vld,
  input  logic       frm_ok,
  input  logic [7:0] frm_addr,
  input  logic [7:0] frm_cmd,
  input  logic       rpt_vld,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_type,
  output logic [7:0] evt_cmd,
  output logic       key_active,
  output logic [7:0] err_cnt,
  output logic       ovf
);

  localparam longint unsigned TMR_LOAD_L = (64'(RELEASE_MS) * 64'(CLK_FREQ)) / 64'd1000;
  localparam int unsigned TW = (TMR_LOAD_L < 64'd2) ? 1 : $clog2(TMR_LOAD_L + 64'd1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TMR_LOAD_L);
  localparam int unsigned RW = $clog2(HOLD_DELAY + 2);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] EV_PRESS = 2'b00;
  localparam logic [1:0] EV_HOLD  = 2'b01;
  localparam logic [1:0] EV_REL   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HOLDING} state_t;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] cmd;
  } evt_t;

  typedef struct packed {
    logic       frm;
    logic       ok;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       rpt;
  } in_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tmr, w_tmr_nxt;
  logic [7:0]      r_cur_cmd, w_cur_cmd_nxt;
  logic [RW-1:0]   r_rpt_cnt, w_rpt_cnt_nxt, w_rpt_inc;
  logic            r_pend_vld, w_pend_vld_nxt;
  logic [7:0]      r_pend_cmd, w_pend_cmd_nxt;
  logic            r_dly_vld, w_dly_vld_nxt;
  in_t             r_dly, w_dly_nxt;
  logic [7:0]      r_err_cnt;
  logic            r_ovf;
  logic            r_key_active;
  logic            w_err_inc;

  in_t             w_live, w_src;
  logic            w_live_any, w_acc;

  logic            w_push_vld;
  evt_t            w_push_evt;

  evt_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CW-1:0]   r_count, w_count_nxt, w_free;
  logic            r_evt_valid;
  evt_t            r_head, w_head_nxt;
  logic            w_wr, w_pop, w_ovf_set;

  // Input staging: an event arriving while a pending PRESS drains is
  // parked for one cycle and consumed ahead of the live inputs.
  assign w_live     = {frm_vld, frm_ok, frm_addr, frm_cmd, rpt_vld};
  assign w_live_any = frm_vld | rpt_vld;
  assign w_src      = r_dly_vld ? r_dly : w_live;
  assign w_acc      = w_src.frm && w_src.ok && (!ADDR_EN || (w_src.addr == ADDR_MATCH));
  assign w_rpt_inc  = r_rpt_cnt + RW'(1);

  // Next-state and event-push decode
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = ((r_state != ST_IDLE) && (r_tmr != '0)) ? r_tmr - TW'(1) : r_tmr;
    w_cur_cmd_nxt  = r_cur_cmd;
    w_rpt_cnt_nxt  = r_rpt_cnt;
    w_pend_vld_nxt = 1'b0;
    w_pend_cmd_nxt = r_pend_cmd;
    w_dly_vld_nxt  = r_dly_vld;
    w_dly_nxt      = r_dly;
    w_err_inc      = 1'b0;
    w_push_vld     = 1'b0;
    w_push_evt     = '0;

    if (r_pend_vld) begin
      // Second half of a key change owns this cycle.
      w_push_vld = 1'b1;
      w_push_evt = '{typ: EV_PRESS, cmd: r_pend_cmd};
      if (!r_dly_vld && w_live_any) begin
        w_dly_vld_nxt = 1'b1;
        w_dly_nxt     = w_live;
      end
    end else begin
      // Parked event is consumed now; a live one arriving meanwhile waits.
      w_dly_vld_nxt = r_dly_vld & w_live_any;
      w_dly_nxt     = w_live;
      w_err_inc     = w_src.frm & ~w_acc;

      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            w_push_vld    = 1'b1;
            w_push_evt    = '{typ: EV_PRESS, cmd: w_src.cmd};
            w_cur_cmd_nxt = w_src.cmd;
            w_rpt_cnt_nxt = '0;
            w_tmr_nxt     = TMR_LOAD;
            w_state_nxt   = ST_PRESSED;
          end
        end
        ST_PRESSED, ST_HOLDING: begin
          if (w_acc) begin
            w_tmr_nxt = TMR_LOAD;
            if (w_src.cmd != r_cur_cmd) begin
              w_push_vld     = 1'b1;
              w_push_evt     = '{typ: EV_REL, cmd: r_cur_cmd};
              w_pend_vld_nxt = 1'b1;
              w_pend_cmd_nxt = w_src.cmd;
              w_cur_cmd_nxt  = w_src.cmd;
              w_rpt_cnt_nxt  = '0;
              w_state_nxt    = ST_PRESSED;
            end
          end else if (w_src.rpt && !w_src.frm) begin
            // A repeat outranks a same-cycle timer expiry.
            w_tmr_nxt = TMR_LOAD;
            if (r_state == ST_PRESSED) begin
              w_rpt_cnt_nxt = w_rpt_inc;
              if (w_rpt_inc >= RW'(HOLD_DELAY)) begin
                w_push_vld  = 1'b1;
                w_push_evt  = '{typ: EV_HOLD, cmd: r_cur_cmd};
                w_state_nxt = ST_HOLDING;
              end
            end else begin
              w_push_vld = 1'b1;
              w_push_evt = '{typ: EV_HOLD, cmd: r_cur_cmd};
            end
          end else if (r_tmr == '0) begin
            w_push_vld  = 1'b1;
            w_push_evt  = '{typ: EV_REL, cmd: r_cur_cmd};
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FIFO admission (judged on pre-pop occupancy) and head prefetch
  always_comb begin
    w_free    = CW'(FIFO_DEPTH) - r_count;
    w_pop     = r_evt_valid & evt_ready;
    w_wr      = 1'b0;
    w_ovf_set = 1'b0;
    if (w_push_vld) begin
      if (w_push_evt.typ == EV_HOLD) begin
        // HOLD leaves room for a RELEASE+PRESS pair.
        w_wr = (w_free >= CW'(3));
      end else begin
        w_wr      = (w_free != '0);
        w_ovf_set = (w_free == '0);
      end
    end
    w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
    w_head_nxt  = (w_wr && (r_wr_ptr == w_rd_nxt)) ? w_push_evt : r_mem[w_rd_nxt];
  end

  // Control and status registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_tmr        <= '0;
      r_cur_cmd    <= '0;
      r_rpt_cnt    <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_cmd   <= '0;
      r_dly_vld    <= 1'b0;
      r_dly        <= '0;
      r_err_cnt    <= '0;
      r_ovf        <= 1'b0;
      r_key_active <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_evt_valid  <= 1'b0;
      r_head       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmr        <= w_tmr_nxt;
      r_cur_cmd    <= w_cur_cmd_nxt;
      r_rpt_cnt    <= w_rpt_cnt_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_pend_cmd   <= w_pend_cmd_nxt;
      r_dly_vld    <= w_dly_vld_nxt;
      r_dly        <= w_dly_nxt;
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_ovf_set) r_ovf <= 1'b1;
      r_key_active <= (w_state_nxt != ST_IDLE);
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr     <= w_rd_nxt;
      r_count      <= w_count_nxt;
      r_evt_valid  <= (w_count_nxt != '0);
      r_head       <= w_head_nxt;
    end
  end

  // Event storage
  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_evt;
  end

  assign evt_valid  = r_evt_valid;
  assign evt_type   = r_head.typ;
  assign evt_cmd    = r_head.cmd;
  assign key_active = r_key_active;
  assign err_cnt    = r_err_cnt;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_inf_key_ctrl.sv
// Bench for inf_key_ctrl: table of directed vectors, hand-written corner
// sequences, then random traffic compared against an event-level model.
module tb_inf_key_ctrl;

  localparam int LOAD = 10;
  localparam int HOLD_DELAY = 3;
  localparam int DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       frm_vld = 1'b0, frm_ok = 1'b0, rpt_vld = 1'b0, evt_ready = 1'b1;
  logic [7:0] frm_addr = 8'h00, frm_cmd = 8'h00;
  logic       evt_valid, key_active, ovf;
  logic [1:0] evt_type;
  logic [7:0] evt_cmd, err_cnt;

  int total = 0;
  int bad = 0;

  inf_key_ctrl #(.CLK_FREQ(1000), .RELEASE_MS(10)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .frm_vld(frm_vld), .frm_ok(frm_ok), .frm_addr(frm_addr), .frm_cmd(frm_cmd),
    .rpt_vld(rpt_vld),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type), .evt_cmd(evt_cmd),
    .key_active(key_active), .err_cnt(err_cnt), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model (event level) ----------------
  typedef struct packed {bit f; bit ok; logic [7:0] a; logic [7:0] c; bit r;} inrec_t;
  inrec_t     m_inq[$];
  logic [9:0] m_fifo[$];
  int         m_state;      // 0 idle, 1 pressed, 2 holding
  logic [7:0] m_cur, m_pcmd;
  int         m_rpt, m_err;
  bit         m_pend, m_ovf;
  longint     m_cyc, m_deadline;

  function automatic void model_reset();
    m_inq.delete(); m_fifo.delete();
    m_state = 0; m_cur = 0; m_pcmd = 0; m_rpt = 0; m_err = 0;
    m_pend = 0; m_ovf = 0; m_cyc = 0; m_deadline = 0;
  endfunction

  function automatic void model_step(inrec_t in, bit rdy);
    bit do_push = 0, reloaded = 0, admit = 0, acc;
    logic [1:0] pt = 2'b00;
    logic [7:0] pc = 8'h00;
    inrec_t r;
    int pre;
    if (in.f || in.r) m_inq.push_back(in);
    if (m_pend) begin
      do_push = 1; pt = 2'b00; pc = m_pcmd; m_pend = 0;
    end else begin
      if (m_inq.size() > 0) begin
        r = m_inq.pop_front();
        acc = r.f && r.ok && (r.a == 8'h57);
        if (r.f && !acc) begin
          if (m_err < 255) m_err++;
        end else if (r.f) begin
          reloaded = 1;
          m_deadline = m_cyc + LOAD + 1;
          if (m_state == 0) begin
            do_push = 1; pt = 2'b00; pc = r.c; m_cur = r.c; m_rpt = 0; m_state = 1;
          end else if (r.c != m_cur) begin
            do_push = 1; pt = 2'b10; pc = m_cur;
            m_pend = 1; m_pcmd = r.c; m_cur = r.c; m_rpt = 0; m_state = 1;
          end
        end else if (r.r && m_state != 0) begin
          reloaded = 1;
          m_deadline = m_cyc + LOAD + 1;
          if (m_state == 1) begin
            m_rpt++;
            if (m_rpt >= HOLD_DELAY) begin do_push = 1; pt = 2'b01; pc = m_cur; m_state = 2; end
          end else begin
            do_push = 1; pt = 2'b01; pc = m_cur;
          end
        end
      end
      if (!reloaded && m_state != 0 && m_cyc >= m_deadline) begin
        do_push = 1; pt = 2'b10; pc = m_cur; m_state = 0;
      end
    end
    pre = m_fifo.size();
    if (do_push) begin
      if (pt == 2'b01) admit = (DEPTH - pre >= 3);
      else begin
        admit = (DEPTH - pre >= 1);
        if (!admit) m_ovf = 1;
      end
    end
    if (pre > 0 && rdy) void'(m_fifo.pop_front());
    if (admit) m_fifo.push_back({pt, pc});
    m_cyc++;
  endfunction

  function automatic logic [20:0] model_exp();
    logic [9:0] h = 10'h0;
    if (m_fifo.size() > 0) h = m_fifo[0];
    return pk(m_fifo.size() > 0, h[9:8], h[7:0], m_state != 0, 8'(m_err), m_ovf);
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [20:0] pk(bit ev, logic [1:0] et, logic [7:0] ec, bit ek,
                                     logic [7:0] ee, bit eo);
    return {ev, ev ? et : 2'b00, ev ? ec : 8'h00, ek, ee, eo};
  endfunction

  function automatic logic [20:0] dut_out();
    return pk(evt_valid, evt_type, evt_cmd, key_active, err_cnt, ovf);
  endfunction

  function automatic void chk(string nm, logic [20:0] act, logic [20:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {v,type,cmd,key,err,ovf}=%h want %h", nm, act, exp);
    end
  endfunction

  task automatic step(bit f, bit ok, logic [7:0] a, logic [7:0] c, bit r, bit rdy);
    inrec_t in;
    frm_vld = f; frm_ok = ok; frm_addr = a; frm_cmd = c; rpt_vld = r; evt_ready = rdy;
    in = '{f: f, ok: ok, a: a, c: c, r: r};
    @(posedge sys_clk);
    model_step(in, rdy);
    #1;
    frm_vld = 1'b0; rpt_vld = 1'b0;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, rdy);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; frm_vld = 1'b0; rpt_vld = 1'b0;
    @(posedge sys_clk);
    model_reset();
    #1;
    sys_rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit f; bit ok; logic [7:0] a; logic [7:0] c; bit r; bit rdy; int idl;
    bit ev; logic [1:0] et; logic [7:0] ec; bit ek; logic [7:0] ee; bit eo;
  } vec_t;
  vec_t vt[$];

  function automatic void v(bit f, bit ok, logic [7:0] a, logic [7:0] c, bit r, bit rdy,
                            int idl, bit ev, logic [1:0] et, logic [7:0] ec, bit ek,
                            logic [7:0] ee, bit eo);
    vt.push_back('{f, ok, a, c, r, rdy, idl, ev, et, ec, ek, ee, eo});
  endfunction

  localparam logic [1:0] P = 2'b00, H = 2'b01, R = 2'b10;

  initial begin
    // press, silence, timeout release
    v(1,1,8'h57,8'h22,0,1,0, 1,P,8'h22,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,8, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,0, 1,R,8'h22,0,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,0,8'd0,0);
    // press, five repeats five cycles apart, timeout
    v(1,1,8'h57,8'h22,0,1,0, 1,P,8'h22,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,3, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,1,1,0, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,3, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,1,1,0, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,3, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,1,1,0, 1,H,8'h22,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,3, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,1,1,0, 1,H,8'h22,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,3, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,1,1,0, 1,H,8'h22,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,9, 0,P,8'h00,1,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,0, 1,R,8'h22,0,8'd0,0);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,0,8'd0,0);
    // rejected frames: wrong address, failed checks
    v(1,1,8'h58,8'h22,0,1,0, 0,P,8'h00,0,8'd1,0);
    v(1,0,8'h57,8'h22,0,1,0, 0,P,8'h00,0,8'd2,0);
    // key change: RELEASE then PRESS on consecutive cycles
    v(1,1,8'h57,8'h22,0,1,0, 1,P,8'h22,1,8'd2,0);
    v(1,1,8'h57,8'h45,0,1,0, 1,R,8'h22,1,8'd2,0);
    v(0,0,8'h00,8'h00,0,1,0, 1,P,8'h45,1,8'd2,0);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,1,8'd2,0);
    v(0,0,8'h00,8'h00,0,1,8, 1,R,8'h45,0,8'd2,0);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,0,8'd2,0);
    // stalled consumer: HOLD reservation, then overflow
    v(1,1,8'h57,8'h22,0,0,0, 1,P,8'h22,1,8'd2,0);
    for (int i = 0; i < 6; i++) v(0,0,8'h00,8'h00,1,0,0, 1,P,8'h22,1,8'd2,0);
    v(1,1,8'h57,8'h45,0,0,0, 1,P,8'h22,1,8'd2,0);
    v(0,0,8'h00,8'h00,0,0,0, 1,P,8'h22,1,8'd2,0);
    v(1,1,8'h57,8'h22,0,0,0, 1,P,8'h22,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,0,0, 1,P,8'h22,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,0, 1,H,8'h22,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,0, 1,R,8'h22,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,0, 1,P,8'h45,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,4, 0,P,8'h00,1,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,0, 1,R,8'h22,0,8'd2,1);
    v(0,0,8'h00,8'h00,0,1,0, 0,P,8'h00,0,8'd2,1);

    do_reset();
    chk("reset_state", dut_out(), pk(0,P,8'h00,0,8'd0,0));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].f, vt[i].ok, vt[i].a, vt[i].c, vt[i].r, vt[i].rdy);
      idle(vt[i].idl, vt[i].rdy);
      chk($sformatf("vec%0d", i), dut_out(),
          pk(vt[i].ev, vt[i].et, vt[i].ec, vt[i].ek, vt[i].ee, vt[i].eo));
    end

    // err_cnt saturation (starts at 2)
    for (int i = 0; i < 252; i++) step(1, 0, 8'h57, 8'h22, 0, 1);
    chk("err_254", dut_out(), pk(0,P,8'h00,0,8'd254,1));
    for (int i = 0; i < 48; i++) step(1, 0, 8'h57, 8'h22, 0, 1);
    chk("err_sat", dut_out(), pk(0,P,8'h00,0,8'd255,1));

    // frame and repeat together: repeat ignored
    do_reset();
    chk("reset_clears", dut_out(), pk(0,P,8'h00,0,8'd0,0));
    step(1, 1, 8'h57, 8'h22, 1, 1);
    chk("frm_rpt_press", dut_out(), pk(1,P,8'h22,1,8'd0,0));
    step(0, 0, 8'h00, 8'h00, 1, 1);
    step(0, 0, 8'h00, 8'h00, 1, 1);
    chk("frm_rpt_nohold", dut_out(), pk(0,P,8'h00,1,8'd0,0));
    step(0, 0, 8'h00, 8'h00, 1, 1);
    chk("frm_rpt_hold", dut_out(), pk(1,H,8'h22,1,8'd0,0));
    idle(10, 1);
    chk("hold_pre_to", dut_out(), pk(0,P,8'h00,1,8'd0,0));
    idle(1, 1);
    chk("hold_timeout", dut_out(), pk(1,R,8'h22,0,8'd0,0));

    // repeat on the expiry cycle wins over the release
    do_reset();
    step(1, 1, 8'h57, 8'h22, 0, 1);
    idle(10, 1);
    chk("exp_pre", dut_out(), pk(0,P,8'h00,1,8'd0,0));
    step(0, 0, 8'h00, 8'h00, 1, 1);
    chk("exp_rpt_wins", dut_out(), pk(0,P,8'h00,1,8'd0,0));
    idle(10, 1);
    chk("exp_rpt_pre", dut_out(), pk(0,P,8'h00,1,8'd0,0));
    idle(1, 1);
    chk("exp_rpt_rel", dut_out(), pk(1,R,8'h22,0,8'd0,0));

    // event arriving during the pending PRESS is deferred, not lost
    do_reset();
    step(1, 1, 8'h57, 8'h22, 0, 1);
    chk("dfr_p22", dut_out(), pk(1,P,8'h22,1,8'd0,0));
    step(1, 1, 8'h57, 8'h45, 0, 1);
    chk("dfr_r22", dut_out(), pk(1,R,8'h22,1,8'd0,0));
    step(1, 1, 8'h57, 8'h77, 0, 1);
    chk("dfr_p45", dut_out(), pk(1,P,8'h45,1,8'd0,0));
    idle(1, 1);
    chk("dfr_r45", dut_out(), pk(1,R,8'h45,1,8'd0,0));
    idle(1, 1);
    chk("dfr_p77", dut_out(), pk(1,P,8'h77,1,8'd0,0));
    idle(1, 1);
    chk("dfr_empty", dut_out(), pk(0,P,8'h00,1,8'd0,0));

    // reset while holding with queued events: no trailing RELEASE
    do_reset();
    step(1, 1, 8'h57, 8'h22, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 1, 0);
    chk("rst_pre", dut_out(), pk(1,P,8'h22,1,8'd0,0));
    do_reset();
    chk("rst_mid", dut_out(), pk(0,P,8'h00,0,8'd0,0));
    for (int i = 0; i < LOAD + 6; i++) begin
      idle(1, 1);
      chk("rst_quiet", dut_out(), pk(0,P,8'h00,0,8'd0,0));
    end

    // random traffic against the model
    do_reset();
    begin
      logic [7:0] cmds [3];
      int gap = 0;
      cmds[0] = 8'h22; cmds[1] = 8'h45; cmds[2] = 8'h77;
      for (int n = 0; n < 4000; n++) begin
        bit rdy = ($urandom_range(0, 3) != 0);
        if (gap > 0) begin
          gap--;
          idle(1, rdy);
        end else begin
          int roll = $urandom_range(0, 9);
          bit ok = ($urandom_range(0, 9) != 0);
          logic [7:0] a = ($urandom_range(0, 7) == 0) ? 8'h58 : 8'h57;
          logic [7:0] c = cmds[$urandom_range(0, 2)];
          if (roll < 4)       step(1, ok, a, c, 0, rdy);
          else if (roll < 8)  step(0, 0, 8'h00, 8'h00, 1, rdy);
          else if (roll == 8) step(1, ok, a, c, 1, rdy);
          else                idle(1, rdy);
          gap = $urandom_range(1, 14);
        end
        chk($sformatf("rand%0d", n), dut_out(), model_exp());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inf_key_ctrl.md
# inf_key_ctrl

Key-event controller that sits downstream of the NEC infrared receiver. It turns decoded frames and repeat-code pulses into a press/hold/release event stream delivered over a valid/ready handshake. It filters frames by remote address, times key release from the absence of repeat codes, and buffers events in a small FIFO for the consuming logic (display, LED or UART blocks).

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- RELEASE_MS, 120: silence time in ms, with no frame or repeat, after which the key counts as released.
- ADDR_MATCH, 8'h57: accepted remote address.
- ADDR_EN, 1: 1 = enforce ADDR_MATCH; 0 = accept any address.
- HOLD_DELAY, 3: number of repeat codes after PRESS before the first HOLD event.
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥4).

- sys_clk  in  1  system clock, single clock domain.
- sys_rst  in  1  synchronous reset, active-high.
- frm_vld  in  1  one-cycle pulse: full frame decoded.
- frm_ok  in  1  inverse-byte checks passed; sampled with frm_vld.
- frm_addr  in  8  frame address; sampled with frm_vld.
- frm_cmd  in  8  frame command; sampled with frm_vld.
- rpt_vld  in  1  one-cycle pulse: repeat code received.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_type  out  2  00 PRESS, 01 HOLD, 10 RELEASE.
- evt_cmd  out  8  command associated with the event.
- key_active  out  1  high in PRESSED or HOLDING.
- err_cnt  out  8  rejected frames, saturates at 255.
- ovf  out  1  sticky: a PRESS or RELEASE was dropped.

## Operation
- Accepted frame: frm_vld & frm_ok & (!ADDR_EN | frm_addr==ADDR_MATCH).
- Rejected frame: any other frm_vld. Increments err_cnt (saturating). No state change.
- Release timer: counts down from RELEASE_MS*CLK_FREQ/1000 cycles; 23 bits at the default parameters. An accepted frame or a rpt_vld in a non-IDLE state reloads it.
- State IDLE:
  - accepted frame: push PRESS(frm_cmd), latch cur_cmd, clear rpt_cnt, load timer, go to PRESSED.
  - rpt_vld: ignored (orphan repeat).
- State PRESSED:
  - rpt_vld: rpt_cnt+1 and reload timer. When rpt_cnt reaches HOLD_DELAY, push HOLD(cur_cmd) and go to HOLDING.
  - accepted frame with the same cmd: reload timer only.
  - accepted frame with a different cmd: push RELEASE(cur_cmd) this cycle, then push PRESS(new cmd) next cycle via a pending register. cur_cmd updates, rpt_cnt clears, stay in PRESSED.
  - timer reaching 0: push RELEASE(cur_cmd), go to IDLE.
- State HOLDING:
  - rpt_vld: push HOLD(cur_cmd) and reload timer.
  - accepted frame: handled as in PRESSED; a different cmd returns to PRESSED.
  - timeout: push RELEASE(cur_cmd), go to IDLE.
- FIFO admission (occupancy taken before any same-cycle pop):
  - HOLD is written only if free ≥ 3, otherwise silently dropped. This reserves space for a RELEASE+PRESS pair.
  - PRESS/RELEASE are written if free ≥ 1, otherwise dropped and ovf set.
- FIFO is first-word fall-through. Pop on evt_valid & evt_ready.

## Timing
- Reset values: evt_valid 0, evt_type 00, evt_cmd 00, key_active 0, err_cnt 0, ovf 0. State IDLE, timer 0, FIFO empty, pending cleared.
- Reset mid-operation clears everything immediately. No RELEASE is emitted.
- Latency: a triggering input in cycle N gives evt_valid=1 in cycle N+1 when the FIFO was empty. key_active changes in cycle N+1.
- Timeout RELEASE appears on evt_valid the cycle after the timer reads 0. Total is RELEASE_MS*CLK_FREQ/1000 + 1 cycles after the last reload.
- Simultaneous frm_vld and rpt_vld: the frame wins and the repeat is ignored.
- rpt_vld in the same cycle as timer expiry: the repeat wins, the timer reloads and no RELEASE is pushed.
- Push while full with a simultaneous pop: the push is refused (full is judged pre-pop).
- The pending PRESS has priority over any new event in the following cycle. A new event arriving in that cycle is deferred one cycle, never lost.
- evt_type and evt_cmd are stable while evt_valid & !evt_ready.

## Test plan
Use CLK_FREQ=1000 and RELEASE_MS=10 (10-cycle timer), evt_ready=1 unless stated.
- Frame addr 8'h57 cmd 8'h22 ok=1, then silence -> PRESS/22 next cycle, key_active=1; RELEASE/22 11 cycles later; key_active=0.
- Frame cmd 22, then 5 rpt_vld 5 cycles apart -> PRESS, HOLD on the 3rd repeat, HOLD on the 4th and 5th repeats, then RELEASE after timeout.
- Frame addr 8'h58, then frame with ok=0 -> no events, err_cnt=2. 300 bad frames -> err_cnt holds 255.
- PRESS cmd 22, then frame cmd 0x45 -> RELEASE/22 and PRESS/45 on consecutive cycles.
- evt_ready=0, PRESS 22 plus 6 repeats -> FIFO holds PRESS, HOLD only (HOLDs dropped), ovf=0. Then cmd 45 frame -> RELEASE/22 and PRESS/45 fill the FIFO. Then a cmd 22 frame forcing a further RELEASE push -> dropped, ovf=1.
- sys_rst asserted while in HOLDING with 2 queued events -> next cycle evt_valid=0, key_active=0, and no RELEASE appears after reset is released.
